// File: rtl/rpn_pkg.sv
// Shared opcode encoding and command-FIFO entry layout for the RPN command path.
package rpn_pkg;

    localparam int OP_W   = 3;
    localparam int DATA_W = 32;

    localparam logic [OP_W-1:0] RPN_OP_NOP   = 3'd0;
    localparam logic [OP_W-1:0] RPN_OP_PUSH  = 3'd1;
    localparam logic [OP_W-1:0] RPN_OP_POP   = 3'd2;
    localparam logic [OP_W-1:0] RPN_OP_ADD   = 3'd3;
    localparam logic [OP_W-1:0] RPN_OP_SUB   = 3'd4;
    localparam logic [OP_W-1:0] RPN_OP_MUL   = 3'd5;
    localparam logic [OP_W-1:0] RPN_OP_CLEAR = 3'd6;
    localparam logic [OP_W-1:0] RPN_OP_ILL   = 3'd7;

    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] value;
    } fifo_entry_t;

endpackage

// File: rtl/rpn_cmd_fifo.sv
// Synchronous command FIFO; head entry is presented combinationally on rd_data.
module rpn_cmd_fifo
    import rpn_pkg::*;
#(
    parameter int FIFO_DEPTH = 8
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              wr_en,
    input  fifo_entry_t                       wr_data,
    input  logic                              rd_en,
    output fifo_entry_t                       rd_data,
    output logic                              full,
    output logic                              empty,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   count
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    fifo_entry_t      mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign full    = (count == CNT_W'(FIFO_DEPTH));
    assign empty   = (count == '0);
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    // NOTE: storage is deliberately not reset; emptiness is tracked by count, so stale words are never observed.
    always_ff @(posedge clock) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

    // Pointers wrap naturally because FIFO_DEPTH is a power of two.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_rd) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_wr, do_rd})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/rpn_command_sequencer.sv
// Buffers calculator commands and issues them as single-cycle op pulses,
// dropping any command that would over- or underflow the tracked stack depth.
module rpn_command_sequencer
    import rpn_pkg::*;
#(
    parameter int STACKDEPTH = 32,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              cmd_valid,
    output logic                              cmd_ready,
    input  logic [OP_W-1:0]                   cmd_op,
    input  logic [DATA_W-1:0]                 cmd_value,
    input  logic                              issue_en,
    input  logic                              err_clear,
    output logic [DATA_W-1:0]                 calc_value,
    output logic                              calc_push,
    output logic                              calc_pop,
    output logic                              calc_add,
    output logic                              calc_sub,
    output logic                              calc_mul,
    output logic                              calc_reset,
    output logic [$clog2(STACKDEPTH+1)-1:0]   depth,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count,
    output logic                              busy,
    output logic                              err_overflow,
    output logic                              err_underflow,
    output logic                              err_badop,
    output logic [15:0]                       ops_issued
);

    localparam int DEPTH_W = $clog2(STACKDEPTH + 1);

    fifo_entry_t        wr_entry;
    fifo_entry_t        head;
    logic               fifo_full;
    logic               fifo_empty;
    logic               issue;
    logic               nxt_push, nxt_pop, nxt_add, nxt_sub, nxt_mul, nxt_reset;
    logic               set_ovf, set_unf, set_bad;
    logic               any_pulse;
    logic [DEPTH_W-1:0] nxt_depth;

    assign wr_entry  = '{op: cmd_op, value: cmd_value};
    assign cmd_ready = !fifo_full;
    assign issue     = issue_en && !fifo_empty;

    rpn_cmd_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .wr_en   (cmd_valid),
        .wr_data (wr_entry),
        .rd_en   (issue),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // NOTE: every decode output gets a default first, so no path through the case can infer a latch.
    always_comb begin
        nxt_push  = 1'b0;
        nxt_pop   = 1'b0;
        nxt_add   = 1'b0;
        nxt_sub   = 1'b0;
        nxt_mul   = 1'b0;
        nxt_reset = 1'b0;
        set_ovf   = 1'b0;
        set_unf   = 1'b0;
        set_bad   = 1'b0;
        nxt_depth = depth;
        if (issue) begin
            case (head.op)
                RPN_OP_PUSH: begin
                    if (32'(depth) == STACKDEPTH) begin
                        set_ovf = 1'b1;
                    end else begin
                        nxt_push  = 1'b1;
                        nxt_depth = depth + DEPTH_W'(1);
                    end
                end
                RPN_OP_POP: begin
                    if (depth == '0) begin
                        set_unf = 1'b1;
                    end else begin
                        nxt_pop   = 1'b1;
                        nxt_depth = depth - DEPTH_W'(1);
                    end
                end
                RPN_OP_ADD, RPN_OP_SUB, RPN_OP_MUL: begin
                    if (32'(depth) < 32'd2) begin
                        set_unf = 1'b1;
                    end else begin
                        nxt_add   = (head.op == RPN_OP_ADD);
                        nxt_sub   = (head.op == RPN_OP_SUB);
                        nxt_mul   = (head.op == RPN_OP_MUL);
                        nxt_depth = depth - DEPTH_W'(1);
                    end
                end
                RPN_OP_CLEAR: begin
                    nxt_reset = 1'b1;
                    nxt_depth = '0;
                end
                RPN_OP_ILL: set_bad = 1'b1;
                default:    ;
            endcase
        end
    end

    assign any_pulse = nxt_push | nxt_pop | nxt_add | nxt_sub | nxt_mul | nxt_reset;
    assign busy      = !fifo_empty | calc_push | calc_pop | calc_add | calc_sub | calc_mul | calc_reset;

    // A new error on the same edge as err_clear wins, so no event is lost.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            calc_push     <= 1'b0;
            calc_pop      <= 1'b0;
            calc_add      <= 1'b0;
            calc_sub      <= 1'b0;
            calc_mul      <= 1'b0;
            calc_reset    <= 1'b1;
            calc_value    <= '0;
            depth         <= '0;
            err_overflow  <= 1'b0;
            err_underflow <= 1'b0;
            err_badop     <= 1'b0;
            ops_issued    <= '0;
        end else begin
            calc_push     <= nxt_push;
            calc_pop      <= nxt_pop;
            calc_add      <= nxt_add;
            calc_sub      <= nxt_sub;
            calc_mul      <= nxt_mul;
            calc_reset    <= nxt_reset;
            depth         <= nxt_depth;
            err_overflow  <= (err_overflow  & ~err_clear) | set_ovf;
            err_underflow <= (err_underflow & ~err_clear) | set_unf;
            err_badop     <= (err_badop     & ~err_clear) | set_bad;
            if (nxt_push)  calc_value <= head.value;
            if (any_pulse) ops_issued <= ops_issued + 16'd1;
        end
    end

endmodule

// File: doc/rpn_command_sequencer.md
Name: rpn_command_sequencer

Overview:
Upstream feeder for the RPN calculator core. Accepts opcode/operand commands from the processor-side register interface over a valid/ready handshake, buffers them in a small FIFO, and issues them as one-cycle push/pop/add/sub/mul/reset pulses. Tracks the calculator stack depth so that over/underflowing commands are dropped and flagged instead of corrupting the stack.

Parameters:
STACKDEPTH, 32, calculator stack depth; must match the calculator instance.
FIFO_DEPTH, 8, command FIFO entries; power of two, >= 2.

Ports:
clock  input  1  system clock
reset  input  1  asynchronous, active-low reset
cmd_valid  input  1  command offered
cmd_ready  output  1  command accepted when cmd_valid && cmd_ready
cmd_op  input  3  opcode: 0 NOP, 1 PUSH, 2 POP, 3 ADD, 4 SUB, 5 MUL, 6 CLEAR, 7 illegal
cmd_value  input  32  operand; used by PUSH only
issue_en  input  1  1 = issue from FIFO head allowed; 0 = hold
err_clear  input  1  one-cycle pulse clears all sticky error flags
calc_value  output  32  operand to calculator
calc_push, calc_pop, calc_add, calc_sub, calc_mul  output  1 each  one-cycle op pulses
calc_reset  output  1  active-high synchronous clear to calculator
depth  output  $clog2(STACKDEPTH+1)  tracked stack occupancy
fifo_count  output  $clog2(FIFO_DEPTH+1)  FIFO occupancy
busy  output  1  FIFO non-empty or op pulse this cycle
err_overflow, err_underflow, err_badop  output  1 each  sticky error flags
ops_issued  output  16  count of pulses actually issued (wraps)

Behaviour:
- Reset (reset low, async): FIFO empty, depth 0, all op pulses 0, calc_value 0, calc_reset 1, errors 0, ops_issued 0. First rising edge after release drives calc_reset 0.
- cmd_ready = (fifo_count != FIFO_DEPTH); combinational from count only, never from cmd_valid.
- Accept: write on edge where cmd_valid && cmd_ready; entry visible at head next cycle. No empty-bypass.
- Issue: on each edge with FIFO non-empty and issue_en=1, pop head and register outputs. Pulse high exactly one cycle; at most one op pulse (or calc_reset) high per cycle. Min latency accept->pulse: 2 edges.
- Same-cycle write and read permitted whenever not full; count unchanged.
- Legality checked at issue against current depth:
  PUSH: depth==STACKDEPTH -> drop, set err_overflow; else calc_push, calc_value=cmd_value, depth+1.
  POP: depth==0 -> drop, set err_underflow; else calc_pop, depth-1.
  ADD/SUB/MUL: depth<2 -> drop, set err_underflow; else pulse, depth-1.
  CLEAR: calc_reset for one cycle, depth 0; always legal.
  NOP: consumed, no pulse, no count.
  op 7: consumed, no pulse, set err_badop.
- Dropped/NOP/illegal entries still take one issue cycle.
- ops_issued increments on every issued pulse incl. CLEAR; wraps 0xFFFF->0.
- calc_value holds last PUSH operand between pushes.
- err_clear and new error same edge: error flag ends set.
- issue_en low: FIFO keeps filling until full; no pulses; depth frozen.
- Reset mid-stream: FIFO contents discarded, in-flight pulse dropped immediately (async).

Decomposition:
- Package rpn_pkg: opcode localparams (RPN_OP_NOP..RPN_OP_ILL), OP_W=3, DATA_W=32, FIFO entry struct {op, value}.
- Sub-module rpn_cmd_fifo: synchronous FIFO, FIFO_DEPTH x 35 bits, wr/rd/full/empty/count, same reset. Sequencer holds depth tracking, issue logic, errors, counter.

Test Plan:
- Reset release -> calc_reset=1 one cycle then 0; depth=0, cmd_ready=1, errors 0.
- PUSH 5, PUSH 7, ADD, issue_en=1 -> calc_push with 5 then 7, then calc_add; depth 1,2,1; ops_issued=3; first pulse 2 edges after first accept.
- POP on depth 0; SUB on depth 1 -> no pulses, err_underflow=1, depth unchanged; err_clear -> 0.
- STACKDEPTH+1 PUSHes (values 1..33) -> 32 calc_push pulses, 33rd dropped, err_overflow=1, depth=32; CLEAR -> calc_reset pulse, depth 0.
- issue_en=0, offer 10 commands -> 8 accepted, cmd_ready=0, fifo_count=8; issue_en=1 -> 8 consecutive single-cycle pulses, cmd_ready back to 1 after first pop.
- Op 7, then err_clear same cycle as second op 7 issue -> err_badop stays 1; reset low mid-burst -> pulses stop at once, fifo_count=0.
